gate_resp_checker: RTL

//  Self-checking driver/monitor for the 2-input gate experiment DUT (outputs and2, or2).

---
 rtl/gate_chk_pkg.sv | 22 ++
 rtl/gate_ref_model.sv | 18 +
 rtl/gate_resp_checker.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg
// Shared types and helpers for the gate response checker family.
//   state_t  : checker FSM state (IDLE, SETTLE, CHECK, DONE), 2-bit encoding
//   NUM_VEC  : number of input vectors in one truth-table sweep of a 2-input gate
//   vec_of() : maps a sweep index to the {x2, x1} pair driven into the gate DUT
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_VEC = 4;

    // x1 takes the low index bit so the sweep runs (x1,x2) = 00,10,01,11
    function automatic logic [1:0] vec_of(input logic [1:0] idx);
        return {idx[1], idx[0]};
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// gate_ref_model
// Combinational golden model of the 2-input gate experiment. Shared by the
// gate experiment checkers so they all agree on the expected responses.
// Ports:
//   x1, x2    in   gate inputs
//   exp_and2  out  expected AND output
//   exp_or2   out  expected OR output
module gate_ref_model (
    input  logic x1,
    input  logic x2,
    output logic exp_and2,
    output logic exp_or2
);

    assign exp_and2 = x1 & x2;
    assign exp_or2  = x1 | x2;

endmodule

// File: rtl/gate_resp_checker.sv
// gate_resp_checker
// Drives the 2-input gate DUT through its truth table (00,10,01,11 as x1,x2),
// holds each vector SETTLE_CYCLES+1 cycles, samples the DUT on the last of
// them and counts mismatches against gate_ref_model. NUM_PASSES sweeps per run.
// Parameters:
//   SETTLE_CYCLES  cycles a vector settles before its check cycle (0 legal)
//   NUM_PASSES     full sweeps per accepted start (>= 1)
//   ERR_W          width of err_cnt; the count saturates at all-ones
// Ports:
//   clk            clock, all logic on posedge
//   rst_n          synchronous active-low reset
//   start          begins a run; only honoured in IDLE or DONE
//   dut_and2       DUT AND output
//   dut_or2        DUT OR output
//   x1, x2         DUT inputs
//   busy           run in progress (SETTLE or CHECK)
//   done           run finished; held until the next accepted start or reset
//   pass           done with no mismatches (registered)
//   err_cnt        saturating mismatch count of the current run
// Optional feature, macro GATE_CHK_FAIL_LOG_EN adds:
//   first_fail_vld out  a mismatch has been seen in this run
//   first_fail_idx out  vector index of the first mismatch of this run
module gate_resp_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dut_and2,
    input  logic             dut_or2,
    output logic             x1,
    output logic             x2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt
`ifdef GATE_CHK_FAIL_LOG_EN
    ,
    output logic             first_fail_vld,
    output logic [1:0]       first_fail_idx
`endif
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [PW-1:0] PASS_LAST   = PW'(NUM_PASSES - 1);
    localparam logic [1:0]    LAST_IDX    = 2'(NUM_VEC - 1);

    // With no settle time a freshly driven vector is checked on the very next cycle
    localparam state_t VEC_ENTRY = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;

    state_t           state;
    logic [1:0]       idx;
    logic [PW-1:0]    pass_cnt;
    logic [SW-1:0]    settle_cnt;
    logic             exp_and2;
    logic             exp_or2;
    logic             mismatch;
    logic [ERR_W-1:0] err_next;

    gate_ref_model u_ref (
        .x1       (x1),
        .x2       (x2),
        .exp_and2 (exp_and2),
        .exp_or2  (exp_or2)
    );

    assign mismatch = (dut_and2 != exp_and2) | (dut_or2 != exp_or2);

    // Error count including the current check; sticks at all-ones
    assign err_next = (mismatch && (err_cnt != '1)) ? err_cnt + ERR_W'(1) : err_cnt;

    assign busy = (state == SETTLE) || (state == CHECK);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            x1         <= 1'b0;
            x2         <= 1'b0;
            idx        <= 2'd0;
            pass_cnt   <= '0;
            settle_cnt <= '0;
            err_cnt    <= '0;
            pass       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        {x2, x1}   <= vec_of(2'd0);
                        idx        <= 2'd0;
                        pass_cnt   <= '0;
                        settle_cnt <= '0;
                        err_cnt    <= '0;
                        pass       <= 1'b0;
                        state      <= VEC_ENTRY;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    err_cnt <= err_next;
                    if ((idx == LAST_IDX) && (pass_cnt == PASS_LAST)) begin
                        // The last vector stays on the DUT inputs while in DONE
                        pass  <= (err_next == '0);
                        state <= DONE;
                    end else begin
                        idx      <= idx + 2'd1;
                        {x2, x1} <= vec_of(idx + 2'd1);
                        if (idx == LAST_IDX) begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end
                        state <= VEC_ENTRY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GATE_CHK_FAIL_LOG_EN
    // Remembers only the first failing vector of a run
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_fail_vld <= 1'b0;
            first_fail_idx <= 2'd0;
        end else if ((state == IDLE || state == DONE) && start) begin
            first_fail_vld <= 1'b0;
            first_fail_idx <= 2'd0;
        end else if ((state == CHECK) && mismatch && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_idx <= idx;
        end
    end
`endif

endmodule
